// File: rtl/vr16_pkg.sv
// Shared VR16 definitions: datapath width, fetch FSM state encoding and
// the instruction register reset value.
package vr16_pkg;

    localparam int XLEN = 16;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        DRAIN,
        HOLD,
        ADVANCE,
        FAULT
    } ifetch_state_t;

    localparam logic [XLEN-1:0] INS_RESET = '0;

endpackage

// File: rtl/instruction_fetch_if.sv
// Instruction memory read bus: request/acknowledge handshake between the
// fetch stage (master) and instruction memory (slave).
interface instruction_fetch_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_ack,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_ack,
        output mem_rdata
    );
endinterface

// File: rtl/ifetch_watchdog.sv
// Memory-request timeout counter for the fetch stage; present only when
// IFETCH_TIMEOUT_EN is defined.
`ifdef IFETCH_TIMEOUT_EN
module ifetch_watchdog #(
    parameter int LIMIT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic count_en,
    output logic expired
);
    localparam logic [7:0] LOAD = 8'(LIMIT - 1);

    logic [7:0] remaining;

    // Reaches zero during the LIMIT-th consecutive cycle without an ack.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            remaining <= LOAD;
        end else if (clear) begin
            remaining <= LOAD;
        end else if (count_en && remaining != 8'd0) begin
            remaining <= remaining - 8'd1;
        end
    end

    assign expired = (remaining == 8'd0);
endmodule
`endif

// File: rtl/instruction_fetch.sv
// VR16 fetch stage: reads the word at pc_in and presents it to decode.
// Optional memory timeout fault is enabled by defining IFETCH_TIMEOUT_EN.
//
// state   | meaning
// IDLE    | after reset/flush, nothing asserted
// REQ     | memory read outstanding at pc_in
// DRAIN   | flushed read still outstanding, data will be dropped
// HOLD    | ins_out valid, waiting for decoder
// ADVANCE | one-cycle ins_count pulse to program_counter
// FAULT   | memory timeout, terminal until reset
module instruction_fetch
    import vr16_pkg::*;
#(
    parameter int ADDR_W         = XLEN,
    parameter int DATA_W         = XLEN,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [ADDR_W-1:0]   pc_in,
    input  logic                flush,
    instruction_fetch_if.master mem,
    output logic                ins_valid,
    input  logic                ins_ready,
    output logic [DATA_W-1:0]   ins_out,
    output logic [ADDR_W-1:0]   ins_addr,
    output logic                ins_count,
    output logic                fetch_fault
);
    ifetch_state_t state_q, state_d;
    logic          req_on;
    logic          take;
    logic          wait_expired;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ins_out  <= DATA_W'(INS_RESET);
            ins_addr <= '0;
        end else if (take) begin
            ins_out  <= mem.mem_rdata;
            ins_addr <= pc_in;
        end
    end

    always_comb begin
        state_d   = state_q;
        req_on    = 1'b0;
        take      = 1'b0;
        ins_valid = 1'b0;
        ins_count = 1'b0;
        case (state_q)
            IDLE: state_d = REQ;
            REQ: begin
                req_on = 1'b1;
                if (mem.mem_ack) begin
                    if (flush) begin
                        state_d = IDLE;
                    end else begin
                        take    = 1'b1;
                        state_d = HOLD;
                    end
                end else if (wait_expired) begin
                    state_d = FAULT;
                end else if (flush) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                req_on = 1'b1;
                if (mem.mem_ack) begin
                    state_d = IDLE;
                end else if (wait_expired) begin
                    state_d = FAULT;
                end
            end
            HOLD: begin
                ins_valid = 1'b1;
                // A flush beats a same-cycle accept so the PC never advances past a discarded word.
                if (flush) begin
                    state_d = IDLE;
                end else if (ins_ready) begin
                    state_d = ADVANCE;
                end
            end
            ADVANCE: begin
                ins_count = 1'b1;
                state_d   = REQ;
            end
            default: state_d = state_q;
        endcase
    end

    assign mem.mem_req  = req_on;
    assign mem.mem_addr = req_on ? pc_in : '0;

`ifdef IFETCH_TIMEOUT_EN
    logic wd_clear;
    logic wd_count;

    assign wd_clear = (state_d == REQ || state_d == DRAIN) && (state_d != state_q);
    assign wd_count = req_on && !mem.mem_ack;

    ifetch_watchdog #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk      (clk),
        .reset    (reset),
        .clear    (wd_clear),
        .count_en (wd_count),
        .expired  (wait_expired)
    );

    assign fetch_fault = (state_q == FAULT);
`else
    wire unused_timeout = (TIMEOUT_CYCLES != 0);

    assign wait_expired = 1'b0;
    assign fetch_fault  = 1'b0;
`endif
endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed handshake scenarios plus a randomized
// run against an output-level behavioural model of the fetch protocol.
module tb_instruction_fetch;
    localparam int AW = 16;
    localparam int DW = 16;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] pc_in;
    logic [AW-1:0] pc_next;
    logic          flush;
    logic          ins_ready;
    logic          ins_valid;
    logic          ins_count;
    logic          fetch_fault;
    logic [DW-1:0] ins_out;
    logic [AW-1:0] ins_addr;
    int            total = 0;
    int            bad   = 0;

    instruction_fetch_if #(.ADDR_W(AW), .DATA_W(DW)) mem_bus ();

    instruction_fetch #(
        .ADDR_W         (AW),
        .DATA_W         (DW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .pc_in       (pc_in),
        .flush       (flush),
        .mem         (mem_bus),
        .ins_valid   (ins_valid),
        .ins_ready   (ins_ready),
        .ins_out     (ins_out),
        .ins_addr    (ins_addr),
        .ins_count   (ins_count),
        .fetch_fault (fetch_fault)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, want finish");
        $fatal(1);
    end

    function automatic logic [DW-1:0] rom(input logic [AW-1:0] a);
        return (a * 16'h9E37) ^ 16'h5A5A;
    endfunction

    task automatic clear_inputs();
        flush             = 1'b0;
        ins_ready         = 1'b0;
        mem_bus.mem_ack   = 1'b0;
        mem_bus.mem_rdata = '0;
    endtask

    // program_counter model: takes the next PC at the edge that ends the ins_count cycle
    task automatic adv();
        logic c;
        c = ins_count;
        @(posedge clk);
        #1;
        if (c) begin
            pc_in   = pc_next;
            pc_next = pc_in + 16'd1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; pc_in = '0; pc_next = 16'd1;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        total++;
        if (mem_bus.mem_req !== 1'b0) begin bad++; $display("FAIL reset_idle: mem_req=%b want 0", mem_bus.mem_req); end
        adv();
        @(negedge clk);
        total++;
        if (mem_bus.mem_req !== 1'b1 || mem_bus.mem_addr !== 16'h0000) begin
            bad++; $display("FAIL reset_first_req: mem_req=%b addr=%h want 1 0000", mem_bus.mem_req, mem_bus.mem_addr);
        end
        adv();
        reset = 1'b1;
        #1;
        total++;
        if ({mem_bus.mem_req, ins_valid, ins_count, fetch_fault, ins_out, ins_addr, mem_bus.mem_addr} !== '0) begin
            bad++;
            $display("FAIL reset_mid_req: req=%b valid=%b count=%b fault=%b out=%h iaddr=%h maddr=%h want all 0",
                     mem_bus.mem_req, ins_valid, ins_count, fetch_fault, ins_out, ins_addr, mem_bus.mem_addr);
        end
        @(posedge clk);
        #1 reset = 1'b0; pc_in = '0; pc_next = 16'd1;
        @(negedge clk);
        total++;
        if (mem_bus.mem_req !== 1'b0) begin bad++; $display("FAIL reset_release_idle: mem_req=%b want 0", mem_bus.mem_req); end
        adv();
        @(negedge clk);
        total++;
        if (mem_bus.mem_req !== 1'b1 || mem_bus.mem_addr !== 16'h0000) begin
            bad++; $display("FAIL reset_release_req: mem_req=%b addr=%h want 1 0000", mem_bus.mem_req, mem_bus.mem_addr);
        end
    endtask

    task automatic test_zero_wait();
        int pulses;
        pulses = 0;
        mem_bus.mem_ack = 1'b1; mem_bus.mem_rdata = 16'h1234; ins_ready = 1'b1;
        adv();
        mem_bus.mem_ack = 1'b0; mem_bus.mem_rdata = '0;
        @(negedge clk);
        pulses += int'(ins_count);
        total++;
        if (ins_valid !== 1'b1 || ins_out !== 16'h1234 || ins_addr !== 16'h0000 || mem_bus.mem_req !== 1'b0) begin
            bad++; $display("FAIL zw_hold: valid=%b out=%h addr=%h req=%b want 1 1234 0000 0",
                            ins_valid, ins_out, ins_addr, mem_bus.mem_req);
        end
        adv();
        @(negedge clk);
        pulses += int'(ins_count);
        total++;
        if (ins_count !== 1'b1 || ins_valid !== 1'b0) begin
            bad++; $display("FAIL zw_advance: count=%b valid=%b want 1 0", ins_count, ins_valid);
        end
        adv();
        ins_ready = 1'b0;
        @(negedge clk);
        pulses += int'(ins_count);
        total++;
        if (mem_bus.mem_req !== 1'b1 || mem_bus.mem_addr !== 16'h0001) begin
            bad++; $display("FAIL zw_next_req: req=%b addr=%h want 1 0001", mem_bus.mem_req, mem_bus.mem_addr);
        end
        total++;
        if (pulses !== 1) begin bad++; $display("FAIL zw_pulses: got %0d want 1", pulses); end
    endtask

    task automatic test_wait_backpressure();
        int pulses;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            logic [2:0]    exp_ctl;
            logic [DW-1:0] exp_out;
            if (i > 0) begin adv(); @(negedge clk); end
            exp_ctl = {i < 4, i >= 4 && i <= 6, i == 7};
            exp_out = (i < 4) ? 16'h1234 : 16'hCAFE;
            pulses += int'(ins_count);
            total++;
            if ({mem_bus.mem_req, ins_valid, ins_count} !== exp_ctl || ins_out !== exp_out) begin
                bad++; $display("FAIL wb_cycle%0d: req/valid/count=%b out=%h want %b %h",
                                i, {mem_bus.mem_req, ins_valid, ins_count}, ins_out, exp_ctl, exp_out);
            end
            if (i >= 4) begin
                total++;
                if (ins_addr !== 16'h0001) begin bad++; $display("FAIL wb_addr%0d: got %h want 0001", i, ins_addr); end
            end
            mem_bus.mem_ack   = (i == 3);
            mem_bus.mem_rdata = (i == 3) ? 16'hCAFE : 16'($urandom);
            ins_ready         = (i >= 6);
        end
        adv();
        clear_inputs();
        @(negedge clk);
        total++;
        if (mem_bus.mem_req !== 1'b1 || mem_bus.mem_addr !== 16'h0002 || pulses !== 1) begin
            bad++; $display("FAIL wb_next_req: req=%b addr=%h pulses=%0d want 1 0002 1",
                            mem_bus.mem_req, mem_bus.mem_addr, pulses);
        end
    endtask

    task automatic test_flush_wait();
        logic exp_req [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        ins_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) begin adv(); @(negedge clk); end
            total++;
            if (mem_bus.mem_req !== exp_req[i] || ins_valid !== 1'b0 || ins_count !== 1'b0 || ins_out !== 16'hCAFE) begin
                bad++; $display("FAIL fw_cycle%0d: req=%b valid=%b count=%b out=%h want %b 0 0 cafe",
                                i, mem_bus.mem_req, ins_valid, ins_count, ins_out, exp_req[i]);
            end
            flush             = (i == 0);
            mem_bus.mem_ack   = (i == 2);
            mem_bus.mem_rdata = (i == 2) ? 16'hBEEF : '0;
        end
        total++;
        if (mem_bus.mem_addr !== 16'h0002) begin bad++; $display("FAIL fw_req_addr: got %h want 0002", mem_bus.mem_addr); end
        clear_inputs();
    endtask

    task automatic test_flush_vs_accept();
        mem_bus.mem_ack = 1'b1; mem_bus.mem_rdata = 16'h7777;
        adv();
        clear_inputs();
        @(negedge clk);
        total++;
        if (ins_valid !== 1'b1 || ins_out !== 16'h7777) begin
            bad++; $display("FAIL fa_hold: valid=%b out=%h want 1 7777", ins_valid, ins_out);
        end
        flush = 1'b1; ins_ready = 1'b1;
        adv();
        clear_inputs();
        @(negedge clk);
        total++;
        if ({mem_bus.mem_req, ins_valid, ins_count} !== 3'b000) begin
            bad++; $display("FAIL fa_idle: req/valid/count=%b want 000", {mem_bus.mem_req, ins_valid, ins_count});
        end
        adv();
        @(negedge clk);
        total++;
        if (mem_bus.mem_req !== 1'b1 || mem_bus.mem_addr !== 16'h0002 || ins_count !== 1'b0 || ins_out !== 16'h7777) begin
            bad++; $display("FAIL fa_refetch: req=%b addr=%h count=%b out=%h want 1 0002 0 7777",
                            mem_bus.mem_req, mem_bus.mem_addr, ins_count, ins_out);
        end
    endtask

    task automatic test_timeout();
        for (int i = 0; i < 7; i++) begin
            logic exp_req;
            logic exp_fault;
            if (i > 0) begin adv(); @(negedge clk); end
`ifdef IFETCH_TIMEOUT_EN
            exp_req   = (i < TO);
            exp_fault = (i >= TO);
`else
            exp_req   = 1'b1;
            exp_fault = 1'b0;
`endif
            total++;
            if (mem_bus.mem_req !== exp_req || fetch_fault !== exp_fault || ins_valid !== 1'b0) begin
                bad++; $display("FAIL to_cycle%0d: req=%b fault=%b valid=%b want %b %b 0",
                                i, mem_bus.mem_req, fetch_fault, ins_valid, exp_req, exp_fault);
            end
        end
        reset = 1'b1;
        #1;
        total++;
        if (fetch_fault !== 1'b0 || mem_bus.mem_req !== 1'b0) begin
            bad++; $display("FAIL to_reset: fault=%b req=%b want 0 0", fetch_fault, mem_bus.mem_req);
        end
        @(posedge clk);
        #1 reset = 1'b0; pc_in = '0; pc_next = 16'd1;
        adv();
        @(negedge clk);
        total++;
        if (mem_bus.mem_req !== 1'b1 || mem_bus.mem_addr !== 16'h0000) begin
            bad++; $display("FAIL to_recover: req=%b addr=%h want 1 0000", mem_bus.mem_req, mem_bus.mem_addr);
        end
    endtask

    // Model works purely from observable protocol rules: what each output must do
    // next cycle given this cycle's expected outputs and the driven inputs.
    task automatic test_random();
        logic          e_req, e_valid, e_count, n_req, n_valid, n_count;
        logic          discard;
        logic          ack;
        logic [DW-1:0] held_word;
        logic [AW-1:0] held_addr;
        int            waits;
        e_req = 1'b1; e_valid = 1'b0; e_count = 1'b0;
        discard = 1'b0; held_word = '0; held_addr = '0; waits = 0;
        for (int n = 0; n < 400; n++) begin
            total++;
            if ({mem_bus.mem_req, ins_valid, ins_count, fetch_fault} !== {e_req, e_valid, e_count, 1'b0}) begin
                bad++; $display("FAIL rnd_ctl%0d: req/valid/count/fault=%b want %b",
                                n, {mem_bus.mem_req, ins_valid, ins_count, fetch_fault}, {e_req, e_valid, e_count, 1'b0});
            end
            total++;
            if (ins_out !== held_word || ins_addr !== held_addr) begin
                bad++; $display("FAIL rnd_word%0d: out=%h addr=%h want %h %h", n, ins_out, ins_addr, held_word, held_addr);
            end
            total++;
            if (mem_bus.mem_addr !== (e_req ? pc_in : 16'h0000)) begin
                bad++; $display("FAIL rnd_maddr%0d: got %h want %h", n, mem_bus.mem_addr, e_req ? pc_in : 16'h0000);
            end

            flush             = ($urandom_range(7) == 0);
            ins_ready         = $urandom_range(1) == 1;
            ack               = e_req && (waits >= 2 || $urandom_range(1) == 1);
            mem_bus.mem_ack   = ack;
            mem_bus.mem_rdata = ack ? rom(pc_in) : 16'($urandom);
            if (e_count && $urandom_range(1) == 1) pc_next = 16'($urandom);

            n_req = 1'b0; n_valid = 1'b0; n_count = 1'b0;
            if (e_count) begin
                n_req = 1'b1;
            end else if (e_req) begin
                if (ack) begin
                    if (!(flush || discard)) begin
                        n_valid   = 1'b1;
                        held_word = rom(pc_in);
                        held_addr = pc_in;
                    end
                    discard = 1'b0;
                end else begin
                    n_req = 1'b1;
                    if (flush) discard = 1'b1;
                end
            end else if (e_valid) begin
                if (!flush) begin
                    n_count = ins_ready;
                    n_valid = !ins_ready;
                end
            end else begin
                n_req = 1'b1;
            end
            waits = (e_req && !ack) ? waits + 1 : 0;

            adv();
            @(negedge clk);
            e_req = n_req; e_valid = n_valid; e_count = n_count;
        end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_wait_backpressure();
        test_flush_wait();
        test_flush_vs_accept();
        test_timeout();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

- Fetch stage of the VR16 core, directly downstream of `program_counter`.
- Takes the current PC value, runs a request/acknowledge read on instruction memory, and holds the returned word for the decoder/control unit under a valid/ready handshake.
- On acceptance it pulses `ins_count` back to `program_counter` so the PC advances, jumps or returns.
- It is the only driver of `ins_count`.

## Interface
Parameters:
- `ADDR_W`, 16, instruction address width; matches PC width.
- `DATA_W`, 16, instruction word width.
- `TIMEOUT_CYCLES`, 15, maximum request cycles before a fetch fault. Only used when `IFETCH_TIMEOUT_EN` is defined; legal range 1..255.

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `pc_in`  in  ADDR_W  `counter_reg` from `program_counter`.
- `flush`  in  1  control unit discards the held or in-flight instruction.
- `mem_req`  out  1  instruction memory read request.
- `mem_addr`  out  ADDR_W  read address; equals `pc_in` while `mem_req` is high.
- `mem_ack`  in  1  memory returns `mem_rdata` this cycle.
- `mem_rdata`  in  DATA_W  instruction word.
- `ins_valid`  out  1  `ins_out` holds a valid instruction.
- `ins_ready`  in  1  decoder accepts this cycle.
- `ins_out`  out  DATA_W  registered instruction.
- `ins_addr`  out  ADDR_W  address `ins_out` was fetched from.
- `ins_count`  out  1  one-cycle advance pulse to `program_counter`.
- `fetch_fault`  out  1  sticky memory-timeout fault.

## Operation
FSM states:
- **IDLE** (after reset or flush):
  - No outputs asserted.
  - Goes to REQ next cycle.
- **REQ**:
  - `mem_req`=1 and `mem_addr`=`pc_in`.
  - `pc_in` is stable because `ins_count`=0.
  - On `mem_ack`: capture `ins_out`←`mem_rdata` and `ins_addr`←`pc_in`, then go to HOLD.
  - On `flush` without `mem_ack`: go to DRAIN.
  - On `flush` together with `mem_ack`: discard the data, go to IDLE.
- **DRAIN**:
  - `mem_req` stays 1 (the request is never withdrawn before ack).
  - On `mem_ack`: discard the data, go to IDLE.
- **HOLD**:
  - `ins_valid`=1; `ins_out` and `ins_addr` are stable.
  - On `ins_valid & ins_ready` with `flush`=0: go to ADVANCE.
  - On `flush`: go to IDLE with no `ins_count`. Flush wins over a simultaneous `ins_ready`.
- **ADVANCE**:
  - `ins_count`=1 for exactly one cycle.
  - Always goes to REQ; `flush` is ignored here because the PC update is already committed.
- **FAULT** (only with the macro):
  - All outputs 0 except `fetch_fault`=1.
  - Terminal until reset.

Datapath rules:
- `ins_out` and `ins_addr` are loaded only on an accepted `mem_ack` in REQ.
- `ins_out` and `ins_addr` keep their value in every other state.
- `mem_addr` is combinational from `pc_in`, gated to 0 outside REQ/DRAIN.

## Timing
- Reset values:
  - State = IDLE.
  - `mem_req`, `ins_valid`, `ins_count`, `fetch_fault` = 0.
  - `ins_out`, `ins_addr`, `mem_addr` = 0.
- Reset asserted in any state, including DRAIN, returns to IDLE immediately. The memory side must also be reset.
- First `mem_req` occurs in the second cycle after reset deassertion.
- Zero-wait memory (ack in the first REQ cycle), with `ins_ready` held high:
  - cycle 1 REQ
  - cycle 2 HOLD
  - cycle 3 ADVANCE
  - cycle 4 REQ at the new PC
  - Throughput is 1 instruction per 3 cycles.
- Each memory wait cycle adds 1 cycle. Each decoder stall cycle adds 1 cycle.
- `program_counter` samples `ins_count` at the end of ADVANCE, so REQ always sees the updated PC, including jump and return targets.

## Configuration
- `IFETCH_TIMEOUT_EN` defined:
  - A wait counter clears on entry to REQ/DRAIN and counts each cycle without `mem_ack`.
  - If `TIMEOUT_CYCLES` consecutive request cycles pass with no ack, next cycle enters FAULT.
  - In FAULT, `mem_req` drops and `fetch_fault` latches 1.
  - An ack in the `TIMEOUT_CYCLES`-th cycle is accepted normally.
- `IFETCH_TIMEOUT_EN` undefined:
  - No counter and no FAULT state; waits forever for the ack.
  - `fetch_fault` is tied to 0.

## Structure
- Shared package `vr16_pkg` holds:
  - `XLEN`=16.
  - The `ifetch_state_t` enum (IDLE, REQ, DRAIN, HOLD, ADVANCE, FAULT).
  - The reset constant for the instruction register.
- One sub-module, `ifetch_watchdog`, holds the timeout counter. Ports: clear, count enable, expired. It is instantiated only under `IFETCH_TIMEOUT_EN`.

## Test plan
- **Reset:** reset high mid-REQ → all outputs 0 immediately; first `mem_req` two cycles after release with `mem_addr`=0x0000.
- **Zero-wait fetch:** `pc_in`=0x0000, ack with `mem_rdata`=0x1234, `ins_ready`=1 → HOLD shows `ins_out`=0x1234 and `ins_addr`=0x0000; `ins_count` high exactly 1 cycle; next REQ at 0x0001.
- **Wait states and backpressure:** ack after 3 wait cycles, `ins_ready` low for 2 cycles → `ins_out` stable throughout; a single `ins_count` pulse; 8 cycles from REQ to next REQ.
- **Flush while waiting:** flush in REQ with ack 2 cycles later (data 0xBEEF) → no `ins_valid`, no `ins_count`; `mem_req` held until ack; then IDLE, then REQ.
- **Flush vs accept:** in HOLD, `flush` and `ins_ready` high together → no `ins_count`; IDLE next cycle.
- **Timeout (macro on, `TIMEOUT_CYCLES`=4):** no ack for 4 request cycles → `fetch_fault`=1 and `mem_req`=0, held until reset. Same stimulus with the macro off → `mem_req` stays high, `fetch_fault`=0.
